// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings and constants for the multiply/divide unit
package mdu_pkg;
  localparam int DEFAULT_WIDTH = 32;
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_e;
  localparam logic [DEFAULT_WIDTH-1:0] DBZ_LO = '1;
endpackage

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: conditional two's-complement negate of product, quotient and remainder
module mdu_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] prod,
  input  logic [WIDTH-1:0]   quo,
  input  logic [WIDTH-1:0]   rem,
  input  logic               neg_p,
  input  logic               neg_r,
  output logic [2*WIDTH-1:0] prod_fix,
  output logic [WIDTH-1:0]   quo_fix,
  output logic [WIDTH-1:0]   rem_fix
);
  assign prod_fix = neg_p ? -prod : prod;
  assign quo_fix  = neg_p ? -quo  : quo;
  assign rem_fix  = neg_r ? -rem  : rem;
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative shift-add multiplier / restoring divider with HI/LO registers
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hilo_we,
  input  logic             hilo_sel,
  input  logic [WIDTH-1:0] hilo_wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  state_e             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   b_q, a_raw;
  logic               is_div, neg_p, neg_r, dbz;
  logic               sgn, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_rem, div_diff;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign busy  = state != IDLE;
  assign sgn   = ~op[0];
  assign a_neg = sgn & src_a[WIDTH-1];
  assign b_neg = sgn & src_b[WIDTH-1];
  assign a_mag = a_neg ? -src_a : src_a;
  assign b_mag = b_neg ? -src_b : src_b;
  // Multiply: acc = {partial product, remaining multiplier bits}, shifting right
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
  assign mul_nxt = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
  // Divide: acc = {remainder, dividend bits / quotient bits}, shifting left
  assign div_rem  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff = div_rem - {1'b0, b_q};
  assign div_nxt  = div_diff[WIDTH] ? {div_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .prod     (acc),
    .quo      (acc[WIDTH-1:0]),
    .rem      (acc[2*WIDTH-1:WIDTH]),
    .neg_p    (neg_p),
    .neg_r    (neg_r),
    .prod_fix (prod_fix),
    .quo_fix  (quo_fix),
    .rem_fix  (rem_fix)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      b_q         <= '0;
      a_raw       <= '0;
      is_div      <= 1'b0;
      neg_p       <= 1'b0;
      neg_r       <= 1'b0;
      dbz         <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            cnt    <= CW'(WIDTH - 1);
            is_div <= op[1];
            neg_p  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            dbz    <= op[1] & (src_b == '0);
            a_raw  <= src_a;
            acc    <= {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
            b_q    <= op[1] ? b_mag : a_mag;
          end else if (hilo_we) begin
            if (hilo_sel) hi <= hilo_wdata;
            else lo <= hilo_wdata;
          end
        end
        RUN: begin
          acc   <= is_div ? div_nxt : mul_nxt;
          cnt   <= cnt - 1'b1;
          state <= (cnt == '0) ? FINISH : RUN;
        end
        FINISH: begin
          state       <= IDLE;
          done        <= 1'b1;
          div_by_zero <= is_div & dbz;
          if (!is_div) {hi, lo} <= prod_fix;
          else if (dbz) begin
            hi <= a_raw;
            lo <= {WIDTH{DBZ_LO[0]}};
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
